// File: rtl/sync_fifo_ctrl.sv
// FIFO controller for an external RAM whose read data arrives one cycle after the read strobe.
// A one-entry holding register keeps pop data stable while the consumer stalls.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [DATA_WIDTH-1:0]        push_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH+2)-1:0]   count,
    output logic                         ram_cen,
    output logic                         ram_wen,
    output logic                         ram_ren,
    output logic [$clog2(DEPTH)-1:0]     ram_waddr,
    output logic [$clog2(DEPTH)-1:0]     ram_raddr,
    output logic [DATA_WIDTH-1:0]        ram_wdata,
    input  logic [DATA_WIDTH-1:0]        ram_rdata
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 2);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  init_done_q;

    logic                  push_fire;
    logic                  pop_fire;
    logic                  rd_en;
    logic [1:0]            out_cnt;

    // Handshakes; a RAM read is issued only when the output stage will be empty next cycle
    always_comb begin
        push_ready = init_done_q && (ram_cnt_q != CNT_WIDTH'(DEPTH)) && !flush;
        push_fire  = push_valid && push_ready;
        pop_valid  = hold_valid_q || rvalid_q;
        pop_data   = hold_valid_q ? hold_data_q : ram_rdata;
        pop_fire   = pop_valid && pop_ready && !flush;
        out_cnt    = 2'(hold_valid_q) + 2'(rvalid_q);
        rd_en      = (ram_cnt_q != '0) && !flush && (out_cnt == 2'(pop_fire));
    end

    assign ram_wen   = push_fire;
    assign ram_waddr = wptr_q;
    assign ram_wdata = push_data;
    assign ram_ren   = rd_en;
    assign ram_raddr = rptr_q;
    assign ram_cen   = push_fire || rd_en;
    assign count     = ram_cnt_q + CNT_WIDTH'(hold_valid_q) + CNT_WIDTH'(rvalid_q);

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        ram_cnt_d    = ram_cnt_q;
        rvalid_d     = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (flush) begin
            wptr_d       = '0;
            rptr_d       = '0;
            ram_cnt_d    = '0;
            hold_valid_d = 1'b0;
        end else begin
            if (push_fire) begin
                wptr_d = wptr_q + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rptr_d = rptr_q + ADDR_WIDTH'(1);
            end
            if (push_fire && !rd_en) begin
                ram_cnt_d = ram_cnt_q + CNT_WIDTH'(1);
            end else if (rd_en && !push_fire) begin
                ram_cnt_d = ram_cnt_q - CNT_WIDTH'(1);
            end
            rvalid_d = rd_en;
            // Park returned data that the consumer did not take this cycle
            if (rvalid_q && !pop_fire) begin
                hold_valid_d = 1'b1;
                hold_data_d  = ram_rdata;
            end else if (hold_valid_q && pop_fire) begin
                hold_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            ram_cnt_q    <= '0;
            rvalid_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            init_done_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rvalid_q     <= rvalid_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            init_done_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural registered-read RAM beside the DUT.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 5;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          flush      = 1'b0;
    logic          push_valid = 1'b0;
    logic          pop_ready  = 1'b0;
    logic [DW-1:0] push_data  = '0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] count;
    logic          ram_cen, ram_wen, ram_ren;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [DEPTH];

    int checks     = 0;
    int failures   = 0;
    int collisions = 0;

    logic [31:0] exp_q [$];

    always #5 clock = ~clock;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .ram_cen    (ram_cen),
        .ram_wen    (ram_wen),
        .ram_ren    (ram_ren),
        .ram_waddr  (ram_waddr),
        .ram_raddr  (ram_raddr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM with registered read, no reset
    always @(posedge clock) begin
        if (ram_cen && ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_cen && ram_ren) ram_rdata <= mem[ram_raddr];
    end

    always @(negedge clock) begin
        if (reset && ram_wen && ram_ren && (ram_waddr == ram_raddr)) collisions++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int pushed, popped, max_cnt, wwraps, rwraps;
        logic [AW-1:0] exp_waddr;
        logic          prev_stall;
        logic [31:0]   prev_data;
        logic [31:0]   front;

        // Reset state
        #1 reset = 1'b0;
        #1;
        check_eq("rst_push_ready", 32'(push_ready), 32'd0);
        check_eq("rst_pop_valid", 32'(pop_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ram_cen", 32'(ram_cen), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check_eq("rel_push_ready_pre_edge", 32'(push_ready), 32'd0);
        tick();
        check_eq("rel_push_ready", 32'(push_ready), 32'd1);
        check_eq("rel_count", 32'(count), 32'd0);

        // First-word latency
        tick();
        push_valid = 1'b1; push_data = 32'h11; pop_ready = 1'b1;
        #1;
        check_eq("s1_push_ready", 32'(push_ready), 32'd1);
        check_eq("s1_ram_wen", 32'(ram_wen), 32'd1);
        check_eq("s1_ram_cen", 32'(ram_cen), 32'd1);
        check_eq("s1_ram_waddr", 32'(ram_waddr), 32'd0);
        tick();
        push_valid = 1'b0;
        #1;
        check_eq("s1_c1_pop_valid", 32'(pop_valid), 32'd0);
        check_eq("s1_c1_count", 32'(count), 32'd1);
        check_eq("s1_c1_ram_ren", 32'(ram_ren), 32'd1);
        check_eq("s1_c1_ram_raddr", 32'(ram_raddr), 32'd0);
        tick(); #1;
        check_eq("s1_c2_pop_valid", 32'(pop_valid), 32'd1);
        check_eq("s1_c2_pop_data", pop_data, 32'h11);
        check_eq("s1_c2_count", 32'(count), 32'd1);
        tick(); #1;
        check_eq("s1_c3_count", 32'(count), 32'd0);
        check_eq("s1_c3_pop_valid", 32'(pop_valid), 32'd0);

        // Fill to DEPTH+1 then drain
        for (int i = 0; i < 17; i++) begin
            tick();
            pop_ready = 1'b0; push_valid = 1'b1; push_data = 32'(i);
            #1;
            check_eq("s2_accept", 32'(push_ready), 32'd1);
        end
        tick();
        push_data = 32'd99;
        #1;
        check_eq("s2_full_ready", 32'(push_ready), 32'd0);
        check_eq("s2_full_count", 32'(count), 32'd17);
        check_eq("s2_full_pop_data", pop_data, 32'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            push_valid = 1'b0; pop_ready = 1'b1;
            #1;
            check_eq("s2_no_bubble", 32'(pop_valid), 32'd1);
            check_eq("s2_drain_data", pop_data, 32'(i));
        end
        tick(); #1;
        check_eq("s2_empty_valid", 32'(pop_valid), 32'd0);
        check_eq("s2_empty_count", 32'(count), 32'd0);

        // Streaming 40 words; pointers start at 2 after the 18 earlier writes
        pushed = 0; popped = 0; max_cnt = 0; wwraps = 0; rwraps = 0;
        exp_waddr = 4'd2;
        pop_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && popped < 40; cyc++) begin
            tick();
            push_valid = (pushed < 40);
            push_data  = 32'h100 + 32'(pushed);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ram_ren && ram_raddr == 4'd15) rwraps++;
            if (push_valid && push_ready) begin
                check_eq("s3_waddr", 32'(ram_waddr), 32'(exp_waddr));
                if (exp_waddr == 4'd15) wwraps++;
                exp_waddr = exp_waddr + 4'd1;
                pushed++;
            end
            if (pop_valid) begin
                check_eq("s3_data", pop_data, 32'h100 + 32'(popped));
                popped++;
            end
        end
        push_valid = 1'b0;
        check_eq("s3_popped", 32'(popped), 32'd40);
        check_eq("s3_max_count", 32'(max_cnt), 32'd2);
        check_eq("s3_wptr_wraps", 32'(wwraps), 32'd2);
        check_eq("s3_rptr_wraps", 32'(rwraps), 32'd2);

        // Random stalls with stability check
        pushed = 0; popped = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 800 && popped < 60; cyc++) begin
            tick();
            push_valid = (pushed < 60) && ($urandom_range(0, 3) != 0);
            push_data  = $urandom();
            pop_ready  = ($urandom_range(0, 2) == 0);
            #1;
            if (prev_stall) begin
                check_eq("s4_stall_valid", 32'(pop_valid), 32'd1);
                check_eq("s4_stall_data", pop_data, prev_data);
            end
            if (push_valid && push_ready) begin
                exp_q.push_back(push_data);
                pushed++;
            end
            if (pop_valid && pop_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("s4_spurious_pop", 32'(pop_valid), 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    check_eq("s4_data", pop_data, front);
                end
                popped++;
            end
            prev_stall = pop_valid && !pop_ready;
            prev_data  = pop_data;
        end
        check_eq("s4_popped", 32'(popped), 32'd60);
        check_eq("s4_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        check_eq("s4_end_count", 32'(count), 32'd0);

        // Flush with nine entries
        for (int i = 0; i < 9; i++) begin
            tick();
            push_valid = 1'b1; push_data = 32'h200 + 32'(i);
            #1;
            check_eq("s5_accept", 32'(push_ready), 32'd1);
        end
        tick();
        push_valid = 1'b0;
        #1;
        check_eq("s5_count9", 32'(count), 32'd9);
        check_eq("s5_head", pop_data, 32'h200);
        tick();
        flush = 1'b1; push_valid = 1'b1; push_data = 32'h55; pop_ready = 1'b1;
        #1;
        check_eq("s5_flush_push_ready", 32'(push_ready), 32'd0);
        check_eq("s5_flush_ram_cen", 32'(ram_cen), 32'd0);
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        check_eq("s5_post_count", 32'(count), 32'd0);
        check_eq("s5_post_valid", 32'(pop_valid), 32'd0);
        tick();
        push_valid = 1'b1; push_data = 32'hAA;
        #1;
        tick();
        push_valid = 1'b0;
        #1;
        tick(); #1;
        check_eq("s5_aa_valid", 32'(pop_valid), 32'd1);
        check_eq("s5_aa_data", pop_data, 32'hAA);
        pop_ready = 1'b1;
        tick(); #1;
        check_eq("s5_aa_drained", 32'(count), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            tick();
            push_valid = 1'b1; push_data = 32'h300 + 32'(i);
            #1;
        end
        tick();
        #1;
        reset = 1'b0;
        #1;
        check_eq("s6_rst_pop_valid", 32'(pop_valid), 32'd0);
        check_eq("s6_rst_push_ready", 32'(push_ready), 32'd0);
        check_eq("s6_rst_count", 32'(count), 32'd0);
        check_eq("s6_rst_ram_cen", 32'(ram_cen), 32'd0);
        push_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("s6_rel_push_ready", 32'(push_ready), 32'd1);
        check_eq("s6_rel_count", 32'(count), 32'd0);
        check_eq("s6_rel_pop_valid", 32'(pop_valid), 32'd0);
        push_valid = 1'b1; push_data = 32'h5A;
        tick();
        push_valid = 1'b0;
        #1;
        check_eq("s6_c1_pop_valid", 32'(pop_valid), 32'd0);
        tick(); #1;
        check_eq("s6_5a_valid", 32'(pop_valid), 32'd1);
        check_eq("s6_5a_data", pop_data, 32'h5A);
        tick(); #1;
        check_eq("s6_after_valid", 32'(pop_valid), 32'd0);
        check_eq("s6_after_count", 32'(count), 32'd0);

        check_eq("ram_addr_collisions", 32'(collisions), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width.
REQ-002 SHALL have parameter DEPTH, default 16, giving RAM entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL derive localparams ADDR_WIDTH = clog2(DEPTH) and CNT_WIDTH = clog2(DEPTH+2).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of all contents.
REQ-007 SHALL have ports push_valid, input, 1; push_ready, output, 1; push_data, input, DATA_WIDTH: the write stream.
REQ-008 SHALL have ports pop_valid, output, 1; pop_ready, input, 1; pop_data, output, DATA_WIDTH: the read stream.
REQ-009 SHALL have port count, output, CNT_WIDTH: total entries held.
REQ-010 SHALL have ports ram_cen, ram_wen, ram_ren, outputs, 1 bit each: RAM strobes.
REQ-011 SHALL have ports ram_waddr, ram_raddr, outputs, ADDR_WIDTH each: RAM addresses.
REQ-012 SHALL have port ram_wdata, output, DATA_WIDTH: RAM write data.
REQ-013 SHALL have port ram_rdata, input, DATA_WIDTH: registered RAM read data, valid the cycle after ram_ren; the RAM holds it while ram_ren=0.

Function
REQ-014 SHALL keep wptr and rptr (ADDR_WIDTH, wrapping DEPTH-1 -> 0), ram_cnt (0..DEPTH), rvalid (read returned this cycle) and hold_valid/hold_data (one-entry holding register).
REQ-015 SHALL drive push_ready = (ram_cnt != DEPTH) && !flush; push_fire = push_valid && push_ready.
REQ-016 SHALL drive pop_valid = hold_valid || rvalid; pop_data = hold_valid ? hold_data : ram_rdata; pop_fire = pop_valid && pop_ready && !flush.
REQ-017 On push_fire SHALL assert ram_wen, with ram_waddr = wptr and ram_wdata = push_data, and increment wptr.
REQ-018 SHALL assert ram_ren, with ram_raddr = rptr, iff ram_cnt > 0 && !flush && (hold_valid + rvalid - pop_fire) == 0, and SHALL then increment rptr and set rvalid next cycle; otherwise rvalid clears.
REQ-019 SHALL drive ram_cen = ram_wen || ram_ren.
REQ-020 SHALL update ram_cnt by +1 on push_fire only, -1 on ram_ren only, and leave it unchanged when both occur.
REQ-021 When rvalid && !pop_fire, SHALL load hold_data <= ram_rdata and set hold_valid; when hold_valid && pop_fire, SHALL clear hold_valid.
REQ-022 SHALL guarantee that hold_valid and rvalid are never both 1 and that wptr == rptr never coincides with both ram_wen and ram_ren in one cycle.
REQ-023 SHALL drive count = ram_cnt + hold_valid + rvalid; maximum capacity is DEPTH+1.
REQ-024 SHALL have a first-word latency of 2: push accepted in cycle t gives pop_valid in cycle t+2.
REQ-025 SHALL sustain 1 pop per cycle while ram_cnt > 0 and pop_ready stays high.
REQ-026 SHALL keep pop_valid and pop_data stable while pop_valid && !pop_ready, unless flush is asserted.
REQ-027 flush=1 SHALL, at the next edge, zero wptr, rptr, ram_cnt, rvalid and hold_valid; no push or pop is accepted in that cycle.
REQ-028 Writes while full (push_ready=0) and pop_ready while empty SHALL have no effect.

Reset
REQ-029 While reset=0, all state SHALL clear asynchronously: wptr, rptr, ram_cnt, rvalid, hold_valid and hold_data = 0.
REQ-030 During reset, outputs SHALL be: push_ready=0, pop_valid=0, count=0, ram strobes=0; push_ready=1 from the first edge after release.
REQ-031 Reset mid-operation SHALL discard all contents with no partial state retained.

Structure
REQ-032 SHALL need no shared package; ADDR_WIDTH and CNT_WIDTH are local to the module.
REQ-033 SHALL contain no sub-module; the RAM is instantiated beside it (same DATA_WIDTH/DEPTH), with its own reset tied inactive.

Verification
REQ-034 Scenario: DEPTH=16, push 0x11 at cycle 0, pop_ready=1 -> pop_valid=1 with pop_data=0x11 at cycle 2; count 1 then 0.
REQ-035 Scenario: push 17 words 0..16 with pop_ready=0 -> the 17th is accepted, push_ready=0 after it, count=17; then draining pops 0..16 back-to-back with no bubbles.
REQ-036 Scenario: continuous push and pop at 1/cycle for 40 words -> in-order data, wptr/rptr wrap twice, count stays at most 2.
REQ-037 Scenario: random pop_ready stalls -> pop_data stable while stalled; no loss, duplication or reordering.
REQ-038 Scenario: flush with count=9 -> next cycle count=0, pop_valid=0; a following push of 0xAA pops as 0xAA.
REQ-039 Scenario: reset driven 0 mid-stream -> outputs zero immediately; after release the FIFO is empty and fully operational.
